pipe_ctrl_unit: RTL and testbench

Registered successor to the combinational main decoder, with hazard handling for the five-stage core. It decodes the ID-stage opcode into a 10-bit control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB registers with valid bits and destination registers. It generates stall, bubble and flush controls for load-use hazards, branch/JAL redirects and data-memory wait states.

---
 rtl/pipe_ctrl_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_unit_pkg / pipe_ctrl_unit
//
// Registered pipeline control for the five-stage core. The ID-stage opcode is
// decoded into a 10-bit control bundle that is carried through the ID/EX,
// EX/MEM and MEM/WB registers together with a valid bit and the destination
// register. The unit also produces the stall, bubble and flush controls for
// load-use hazards, branch/JAL redirects and data-memory wait states.
//
// Optional feature macro: PIPE_CTRL_FORWARD_EN
//   defined   : adds fwd_a/fwd_b operand-forwarding selects and stalls only on
//               a true load-use hazard against EX.
//   undefined : no forwarding ports; any RAW hazard against a writer in EX or
//               MEM stalls ID until the producer reaches WB.
//
// Parameters:
//   REG_AW            register-address width
//   MEM_TIMEOUT       max data-memory wait cycles before the access is aborted
//   X0_WRITE_SUPPRESS 1 = decoded reg_w_en cleared when rd is x0
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   id_valid, id_opcode             ID-stage instruction valid and opcode
//   id_rs1, id_rs2, id_rd           ID-stage register addresses
//   ex_branch_cond                  branch compare result resolved in EX
//   dmem_ack                        data memory completes the request this cycle
//   ex_ctrl, mem_ctrl, wb_ctrl      per-stage control bundles
//     bit order {imsel,branch_en,jal,reg_w_en,mem_r_en,mem_w_en,aluop[1:0],wbsel[1:0]}
//   ex_rd, mem_rd, wb_rd            per-stage destination registers
//   pc_stall, ifid_stall            hold PC / IF/ID
//   ifid_flush                      IF/ID loads a bubble next edge
//   branch_taken                    redirect PC to the EX target this cycle
//   dmem_req                        MEM-stage access request
//   mem_timeout                     sticky memory timeout flag
//   illegal_op                      ID holds a valid instruction with an unknown opcode
//   fwd_a, fwd_b (macro only)       EX operand sources: 00 regfile, 01 EX/MEM, 10 MEM/WB
// ----------------------------------------------------------------------------

package pipe_ctrl_unit_pkg;

    localparam int unsigned CTRL_W = 10;

    // Control bundle carried down the pipeline.
    typedef struct packed {
        logic       imsel;
        logic       branch_en;
        logic       jal;
        logic       reg_w_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic [1:0] aluop;
        logic [1:0] wbsel;
    } ctrl_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ICALC  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

endpackage

module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int unsigned REG_AW            = 5,
    parameter int unsigned MEM_TIMEOUT       = 16,
    parameter bit          X0_WRITE_SUPPRESS = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [6:0]          id_opcode,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                ex_branch_cond,
    input  logic                dmem_ack,
    output logic [CTRL_W-1:0]   ex_ctrl,
    output logic [CTRL_W-1:0]   mem_ctrl,
    output logic [CTRL_W-1:0]   wb_ctrl,
    output logic [REG_AW-1:0]   ex_rd,
    output logic [REG_AW-1:0]   mem_rd,
    output logic [REG_AW-1:0]   wb_rd,
    output logic                pc_stall,
    output logic                ifid_stall,
    output logic                ifid_flush,
    output logic                branch_taken,
    output logic                dmem_req,
    output logic                mem_timeout,
`ifdef PIPE_CTRL_FORWARD_EN
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
`endif
    output logic                illegal_op
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {
        RUN   = 1'b0,
        MWAIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic              ex_valid, mem_valid, wb_valid;
    ctrl_t             ex_q, mem_q, wb_q;
    logic [REG_AW-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
`ifdef PIPE_CTRL_FORWARD_EN
    logic [REG_AW-1:0] ex_rs1_q, ex_rs2_q;
`endif

    // FSM and wait counter
    state_t            state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt, cnt_nxt;
    logic              timeout_flag;

    // Combinational control
    ctrl_t             id_bundle;
    ctrl_t             wb_in;
    logic              rs1_used, rs2_used, op_known;
    logic              freeze, timeout_now, redirect;
    logic              raw_ex, raw_mem, load_use, stall_lu, id_take;

    // ------------------------------------------------------------------
    // ID-stage decode
    // ------------------------------------------------------------------
    always_comb begin
        id_bundle = '0;
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        op_known  = 1'b1;
        case (id_opcode)
            OP_R: begin
                id_bundle.reg_w_en = 1'b1;
                rs1_used           = 1'b1;
                rs2_used           = 1'b1;
            end
            OP_LOAD: begin
                id_bundle.reg_w_en = 1'b1;
                id_bundle.mem_r_en = 1'b1;
                id_bundle.imsel    = 1'b1;
                id_bundle.aluop    = 2'b01;
                id_bundle.wbsel    = 2'b01;
                rs1_used           = 1'b1;
            end
            OP_STORE: begin
                id_bundle.mem_w_en = 1'b1;
                id_bundle.imsel    = 1'b1;
                id_bundle.aluop    = 2'b01;
                rs1_used           = 1'b1;
                rs2_used           = 1'b1;
            end
            OP_ICALC: begin
                id_bundle.reg_w_en = 1'b1;
                id_bundle.imsel    = 1'b1;
                rs1_used           = 1'b1;
            end
            OP_BRANCH: begin
                id_bundle.branch_en = 1'b1;
                rs1_used            = 1'b1;
                rs2_used            = 1'b1;
            end
            OP_JAL: begin
                id_bundle.reg_w_en = 1'b1;
                id_bundle.jal      = 1'b1;
                id_bundle.wbsel    = 2'b10;
            end
            OP_LUI: begin
                id_bundle.reg_w_en = 1'b1;
                id_bundle.aluop    = 2'b10;
            end
            default: op_known = 1'b0;
        endcase
        if (X0_WRITE_SUPPRESS && (id_rd == '0)) begin
            id_bundle.reg_w_en = 1'b0;
        end
    end

    assign illegal_op = id_valid & ~op_known;

    // MEM-stage request is live whenever a valid memory op sits in EX/MEM.
    assign dmem_req = mem_valid & (mem_q.mem_r_en | mem_q.mem_w_en);

    // ------------------------------------------------------------------
    // Memory-wait FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= cnt_nxt;
            if (timeout_now) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    // Memory-wait FSM: next state, counter and freeze/timeout decisions
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = '0;
        freeze      = 1'b0;
        timeout_now = 1'b0;
        case (state)
            RUN: begin
                if (dmem_req && !dmem_ack) begin
                    state_nxt = MWAIT;
                    freeze    = 1'b1;
                    cnt_nxt   = wait_cnt + CNT_W'(1);
                end
            end
            MWAIT: begin
                if (dmem_ack) begin
                    state_nxt = RUN;
                end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
                    // Abort: let the access retire without a register write.
                    state_nxt   = RUN;
                    timeout_now = 1'b1;
                end else begin
                    freeze  = 1'b1;
                    cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Sticky flag is also visible in the cycle the timeout occurs.
    assign mem_timeout = timeout_flag | timeout_now;

    // ------------------------------------------------------------------
    // Hazard detection and stall/flush controls
    // ------------------------------------------------------------------
    always_comb begin
        raw_ex  = ex_valid & ex_q.reg_w_en & (ex_rd_q != '0) &
                  ((rs1_used & (ex_rd_q == id_rs1)) | (rs2_used & (ex_rd_q == id_rs2)));
        raw_mem = mem_valid & mem_q.reg_w_en & (mem_rd_q != '0) &
                  ((rs1_used & (mem_rd_q == id_rs1)) | (rs2_used & (mem_rd_q == id_rs2)));
`ifdef PIPE_CTRL_FORWARD_EN
        // Forwarding covers everything except a load result still in EX.
        load_use = id_valid & ex_q.mem_r_en & raw_ex;
`else
        // Without forwarding the consumer waits until the producer is in WB.
        load_use = id_valid & (raw_ex | raw_mem);
`endif
        redirect     = ex_valid & ((ex_q.branch_en & ex_branch_cond) | ex_q.jal);
        branch_taken = redirect & ~freeze;
        // A redirect flushes the ID instruction, so its stall is moot.
        stall_lu     = load_use & ~freeze & ~redirect;
        pc_stall     = freeze | stall_lu;
        ifid_stall   = freeze | stall_lu;
        ifid_flush   = branch_taken;
        id_take      = id_valid & ~redirect & ~load_use;

        wb_in = mem_q;
        if (timeout_now) begin
            wb_in.reg_w_en = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // ID/EX, EX/MEM, MEM/WB registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_q      <= '0;
            ex_rd_q   <= '0;
            mem_valid <= 1'b0;
            mem_q     <= '0;
            mem_rd_q  <= '0;
            wb_valid  <= 1'b0;
            wb_q      <= '0;
            wb_rd_q   <= '0;
`ifdef PIPE_CTRL_FORWARD_EN
            ex_rs1_q  <= '0;
            ex_rs2_q  <= '0;
`endif
        end else if (freeze) begin
            // Everything upstream of MEM/WB holds; WB gets a bubble.
            wb_valid <= 1'b0;
            wb_q     <= '0;
            wb_rd_q  <= '0;
        end else begin
            wb_valid  <= mem_valid;
            wb_q      <= wb_in;
            wb_rd_q   <= mem_rd_q;
            mem_valid <= ex_valid;
            mem_q     <= ex_q;
            mem_rd_q  <= ex_rd_q;
            if (id_take) begin
                ex_valid <= 1'b1;
                ex_q     <= id_bundle;
                ex_rd_q  <= id_rd;
`ifdef PIPE_CTRL_FORWARD_EN
                ex_rs1_q <= rs1_used ? id_rs1 : '0;
                ex_rs2_q <= rs2_used ? id_rs2 : '0;
`endif
            end else begin
                ex_valid <= 1'b0;
                ex_q     <= '0;
                ex_rd_q  <= '0;
`ifdef PIPE_CTRL_FORWARD_EN
                ex_rs1_q <= '0;
                ex_rs2_q <= '0;
`endif
            end
        end
    end

    // Stage outputs are zero whenever the stage holds no instruction.
    assign ex_ctrl  = ex_valid  ? CTRL_W'(ex_q)  : '0;
    assign mem_ctrl = mem_valid ? CTRL_W'(mem_q) : '0;
    assign wb_ctrl  = wb_valid  ? CTRL_W'(wb_q)  : '0;
    assign ex_rd    = ex_valid  ? ex_rd_q  : '0;
    assign mem_rd   = mem_valid ? mem_rd_q : '0;
    assign wb_rd    = wb_valid  ? wb_rd_q  : '0;

`ifdef PIPE_CTRL_FORWARD_EN
    // EX operand source select; the younger EX/MEM result wins.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (wb_valid && wb_q.reg_w_en && (wb_rd_q != '0) && (wb_rd_q == ex_rs1_q)) begin
            fwd_a = 2'b10;
        end
        if (mem_valid && mem_q.reg_w_en && (mem_rd_q != '0) && (mem_rd_q == ex_rs1_q)) begin
            fwd_a = 2'b01;
        end
        if (wb_valid && wb_q.reg_w_en && (wb_rd_q != '0) && (wb_rd_q == ex_rs2_q)) begin
            fwd_b = 2'b10;
        end
        if (mem_valid && mem_q.reg_w_en && (mem_rd_q != '0) && (mem_rd_q == ex_rs2_q)) begin
            fwd_b = 2'b01;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// ----------------------------------------------------------------------------
// tb_pipe_ctrl_unit
//
// Directed bench for pipe_ctrl_unit (default build, MEM_TIMEOUT=4): reset,
// load-use stall, branch redirect, memory wait freeze, memory timeout,
// illegal opcode, JAL to x0 and asynchronous reset during a memory wait.
// ----------------------------------------------------------------------------
module tb_pipe_ctrl_unit;

    localparam int unsigned REG_AW = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ICALC  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    // Expected bundles {imsel,branch_en,jal,reg_w_en,mem_r_en,mem_w_en,aluop,wbsel}
    localparam logic [9:0] B_R       = 10'b0001000000;
    localparam logic [9:0] B_LD      = 10'b1001100101;
    localparam logic [9:0] B_LD_NOWR = 10'b1000100101;
    localparam logic [9:0] B_ST      = 10'b1000010100;
    localparam logic [9:0] B_I       = 10'b1001000000;
    localparam logic [9:0] B_BR      = 10'b0100000000;
    localparam logic [9:0] B_LUI     = 10'b0001001000;
    localparam logic [9:0] B_JAL0    = 10'b0010000010;

    logic              clk;
    logic              rst_n;
    logic              id_valid;
    logic [6:0]        id_opcode;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              ex_branch_cond;
    logic              dmem_ack;
    logic [9:0]        ex_ctrl, mem_ctrl, wb_ctrl;
    logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
    logic              pc_stall, ifid_stall, ifid_flush, branch_taken;
    logic              dmem_req, mem_timeout, illegal_op;
`ifdef PIPE_CTRL_FORWARD_EN
    logic [1:0]        fwd_a, fwd_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pipe_ctrl_unit #(
        .REG_AW            (REG_AW),
        .MEM_TIMEOUT       (4),
        .X0_WRITE_SUPPRESS (1'b1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_opcode      (id_opcode),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .ex_branch_cond (ex_branch_cond),
        .dmem_ack       (dmem_ack),
        .ex_ctrl        (ex_ctrl),
        .mem_ctrl       (mem_ctrl),
        .wb_ctrl        (wb_ctrl),
        .ex_rd          (ex_rd),
        .mem_rd         (mem_rd),
        .wb_rd          (wb_rd),
        .pc_stall       (pc_stall),
        .ifid_stall     (ifid_stall),
        .ifid_flush     (ifid_flush),
        .branch_taken   (branch_taken),
        .dmem_req       (dmem_req),
        .mem_timeout    (mem_timeout),
`ifdef PIPE_CTRL_FORWARD_EN
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
`endif
        .illegal_op     (illegal_op)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [6:0] op,
                          input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b,
                          input logic [REG_AW-1:0] d);
        id_valid  = v;
        id_opcode = op;
        id_rs1    = a;
        id_rs2    = b;
        id_rd     = d;
    endtask

    initial begin
        // ---- 1: reset with an R instruction held in ID ----
        rst_n          = 1'b0;
        ex_branch_cond = 1'b0;
        dmem_ack       = 1'b1;
        set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd3);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_ctrl",   32'(ex_ctrl), 32'd0);
        chk("rst_mem_ctrl",  32'(mem_ctrl), 32'd0);
        chk("rst_wb_ctrl",   32'(wb_ctrl), 32'd0);
        chk("rst_ex_rd",     32'(ex_rd), 32'd0);
        chk("rst_pc_stall",  32'(pc_stall), 32'd0);
        chk("rst_flush",     32'(ifid_flush), 32'd0);
        chk("rst_taken",     32'(branch_taken), 32'd0);
        chk("rst_dmem_req",  32'(dmem_req), 32'd0);
        chk("rst_timeout",   32'(mem_timeout), 32'd0);
        chk("rst_illegal",   32'(illegal_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ex_ctrl",   32'(ex_ctrl), 32'd0);
        cyc();
        chk("first_ex_ctrl", 32'(ex_ctrl), 32'(B_R));
        chk("first_ex_rd",   32'(ex_rd), 32'd3);
        set_id(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
        repeat (3) cyc();

        // ---- 2: LW x5 then ADD x6,x5,x1 (no forwarding: 2 stall cycles) ----
        set_id(1'b1, OP_LOAD, 5'd2, 5'd0, 5'd5);
        #1;
        chk("lu_a_stall",    32'(pc_stall), 32'd0);
        cyc();
        set_id(1'b1, OP_R, 5'd5, 5'd1, 5'd6);
        #1;
        chk("lu_b_ex_ctrl",  32'(ex_ctrl), 32'(B_LD));
        chk("lu_b_stall",    32'(pc_stall), 32'd1);
        chk("lu_b_ifid",     32'(ifid_stall), 32'd1);
        cyc();
        chk("lu_c_ex_ctrl",  32'(ex_ctrl), 32'd0);
        chk("lu_c_mem_ctrl", 32'(mem_ctrl), 32'(B_LD));
        chk("lu_c_req",      32'(dmem_req), 32'd1);
        chk("lu_c_stall",    32'(pc_stall), 32'd1);
        cyc();
        chk("lu_d_ex_ctrl",  32'(ex_ctrl), 32'd0);
        chk("lu_d_wb_ctrl",  32'(wb_ctrl), 32'(B_LD));
        chk("lu_d_wb_rd",    32'(wb_rd), 32'd5);
        chk("lu_d_stall",    32'(pc_stall), 32'd0);
        cyc();

        // ---- 3: BEQ taken in EX ----
        set_id(1'b1, OP_BRANCH, 5'd1, 5'd2, 5'd0);
        #1;
        chk("lu_e_ex_ctrl",  32'(ex_ctrl), 32'(B_R));
        chk("lu_e_ex_rd",    32'(ex_rd), 32'd6);
        chk("br_e_stall",    32'(pc_stall), 32'd0);
        cyc();
        set_id(1'b1, OP_ICALC, 5'd3, 5'd0, 5'd7);
        ex_branch_cond = 1'b1;
        #1;
        chk("br_ex_ctrl",    32'(ex_ctrl), 32'(B_BR));
        chk("br_taken",      32'(branch_taken), 32'd1);
        chk("br_flush",      32'(ifid_flush), 32'd1);
        chk("br_no_stall",   32'(pc_stall), 32'd0);
        cyc();
        set_id(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
        ex_branch_cond = 1'b0;
        #1;
        chk("br_g_ex_ctrl",  32'(ex_ctrl), 32'd0);
        chk("br_g_mem_ctrl", 32'(mem_ctrl), 32'(B_BR));
        chk("br_g_taken",    32'(branch_taken), 32'd0);
        cyc();
        chk("br_h_mem_ctrl", 32'(mem_ctrl), 32'd0);
        chk("br_h_ex_ctrl",  32'(ex_ctrl), 32'd0);
        repeat (2) cyc();

        // ---- 4: SW in MEM with ack low for 3 cycles ----
        set_id(1'b1, OP_STORE, 5'd2, 5'd3, 5'd0);
        cyc();
        set_id(1'b1, OP_R, 5'd8, 5'd9, 5'd10);
        cyc();
        set_id(1'b1, OP_LUI, 5'd0, 5'd0, 5'd11);
        dmem_ack = 1'b0;
        #1;
        chk("sw1_req",       32'(dmem_req), 32'd1);
        chk("sw1_stall",     32'(pc_stall), 32'd1);
        chk("sw1_ifid",      32'(ifid_stall), 32'd1);
        cyc();
        chk("sw2_req",       32'(dmem_req), 32'd1);
        chk("sw2_stall",     32'(pc_stall), 32'd1);
        chk("sw2_wb_ctrl",   32'(wb_ctrl), 32'd0);
        chk("sw2_ex_ctrl",   32'(ex_ctrl), 32'(B_R));
        chk("sw2_mem_ctrl",  32'(mem_ctrl), 32'(B_ST));
        cyc();
        chk("sw3_req",       32'(dmem_req), 32'd1);
        chk("sw3_stall",     32'(pc_stall), 32'd1);
        chk("sw3_wb_ctrl",   32'(wb_ctrl), 32'd0);
        cyc();
        dmem_ack = 1'b1;
        #1;
        chk("sw4_req",       32'(dmem_req), 32'd1);
        chk("sw4_stall",     32'(pc_stall), 32'd0);
        chk("sw4_wb_ctrl",   32'(wb_ctrl), 32'd0);
        cyc();
        set_id(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
        #1;
        chk("sw5_wb_ctrl",   32'(wb_ctrl), 32'(B_ST));
        chk("sw5_mem_ctrl",  32'(mem_ctrl), 32'(B_R));
        chk("sw5_mem_rd",    32'(mem_rd), 32'd10);
        chk("sw5_ex_ctrl",   32'(ex_ctrl), 32'(B_LUI));
        chk("sw5_req",       32'(dmem_req), 32'd0);
        repeat (3) cyc();

        // ---- 5: load timeout with MEM_TIMEOUT=4 ----
        set_id(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd9);
        cyc();
        set_id(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
        cyc();
        dmem_ack = 1'b0;
        #1;
        chk("to1_req",       32'(dmem_req), 32'd1);
        chk("to1_stall",     32'(pc_stall), 32'd1);
        chk("to1_timeout",   32'(mem_timeout), 32'd0);
        repeat (3) cyc();
        chk("to4_stall",     32'(pc_stall), 32'd1);
        chk("to4_timeout",   32'(mem_timeout), 32'd0);
        cyc();
        chk("to5_req",       32'(dmem_req), 32'd1);
        chk("to5_timeout",   32'(mem_timeout), 32'd1);
        chk("to5_stall",     32'(pc_stall), 32'd0);
        cyc();
        dmem_ack = 1'b1;
        set_id(1'b1, OP_ICALC, 5'd9, 5'd0, 5'd12);
        #1;
        chk("to6_wb_ctrl",   32'(wb_ctrl), 32'(B_LD_NOWR));
        chk("to6_wb_rd",     32'(wb_rd), 32'd9);
        chk("to6_sticky",    32'(mem_timeout), 32'd1);
        chk("to6_req",       32'(dmem_req), 32'd0);
        chk("to6_stall",     32'(pc_stall), 32'd0);
        cyc();
        set_id(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
        #1;
        chk("to7_ex_ctrl",   32'(ex_ctrl), 32'(B_I));
        cyc();

        // ---- 6: illegal opcode, then JAL x0 ----
        set_id(1'b0, OP_BAD, 5'd0, 5'd0, 5'd1);
        #1;
        chk("ill_novalid",   32'(illegal_op), 32'd0);
        set_id(1'b1, OP_BAD, 5'd0, 5'd0, 5'd1);
        #1;
        chk("ill_flag",      32'(illegal_op), 32'd1);
        cyc();
        set_id(1'b1, OP_JAL, 5'd0, 5'd0, 5'd0);
        #1;
        chk("ill_ex_ctrl",   32'(ex_ctrl), 32'd0);
        chk("jal_illegal",   32'(illegal_op), 32'd0);
        cyc();
        set_id(1'b1, OP_ICALC, 5'd4, 5'd0, 5'd13);
        #1;
        chk("jal_ex_ctrl",   32'(ex_ctrl), 32'(B_JAL0));
        chk("jal_taken",     32'(branch_taken), 32'd1);
        chk("jal_flush",     32'(ifid_flush), 32'd1);
        chk("ill_mem_ctrl",  32'(mem_ctrl), 32'd0);
        cyc();
        chk("jal_bubble",    32'(ex_ctrl), 32'd0);

        // ---- 7: async reset abandons an outstanding access ----
        set_id(1'b1, OP_STORE, 5'd1, 5'd2, 5'd0);
        cyc();
        set_id(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
        cyc();
        dmem_ack = 1'b0;
        #1;
        chk("ar_req_on",     32'(dmem_req), 32'd1);
        cyc();
        chk("ar_frozen",     32'(pc_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_req_off",    32'(dmem_req), 32'd0);
        chk("ar_stall_off",  32'(pc_stall), 32'd0);
        chk("ar_timeout",    32'(mem_timeout), 32'd0);
        chk("ar_mem_ctrl",   32'(mem_ctrl), 32'd0);
        rst_n = 1'b1;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
